// File: rtl/wb_master.sv
// Single-outstanding Wishbone classic master: core load/store requests become WB cycles.
// Optional ACK timeout abort is compiled in when WB_TIMEOUT_EN is defined.
module wb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [1:0]              size_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    ready_o,
    output logic                    done_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o,
    output logic [ADDR_WIDTH-1:0]   ADR_O,
    output logic [DATA_WIDTH-1:0]   DAT_O,
    input  logic [DATA_WIDTH-1:0]   DAT_I,
    output logic                    WE_O,
    output logic [DATA_WIDTH/8-1:0] SEL_O,
    output logic                    STB_O,
    output logic                    CYC_O,
    input  logic                    ACK_I
);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, RELEASE} state_t;

    state_t                    state_q, state_d;
    logic                      stb_q, stb_d;
    logic                      we_q, we_d;
    logic [DATA_WIDTH/8-1:0]   sel_q, sel_d;
    logic [ADDR_WIDTH-1:0]     adr_q, adr_d;
    logic [DATA_WIDTH-1:0]     dat_q, dat_d;
    logic [1:0]                size_q, size_d;
    logic                      ready_q, ready_d;
    logic                      done_q, done_d;
    logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;

`ifdef WB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      err_q, err_d;
`endif

    function automatic logic [DATA_WIDTH/8-1:0] sel_for(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   sel_for = 4'b0001 << a;
            2'b01:   sel_for = a[1] ? 4'b1100 : 4'b0011;
            default: sel_for = 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] lanes_for(input logic [1:0] size, input logic [DATA_WIDTH-1:0] w);
        case (size)
            2'b00:   lanes_for = {4{w[7:0]}};
            2'b01:   lanes_for = {2{w[15:0]}};
            default: lanes_for = w;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] extract(input logic [1:0] size, input logic [1:0] a,
                                                      input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] shifted;
        case (size)
            2'b00: begin
                shifted = d >> {a, 3'b000};
                extract = {24'd0, shifted[7:0]};
            end
            2'b01: begin
                shifted = d >> {a[1], 4'b0000};
                extract = {16'd0, shifted[15:0]};
            end
            default: extract = d;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        stb_d   = stb_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        size_d  = size_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;
`ifdef WB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (req_i) begin
                    state_d = WAIT_ACK;
                    stb_d   = 1'b1;
                    ready_d = 1'b0;
                    we_d    = we_i;
                    adr_d   = addr_i;
                    sel_d   = sel_for(size_i, addr_i[1:0]);
                    dat_d   = we_i ? lanes_for(size_i, wdata_i) : '0;
                    size_d  = size_i;
`ifdef WB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            WAIT_ACK: begin
                // ACK is checked first so it wins over a coincident timeout
                if (ACK_I) begin
                    state_d = RELEASE;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = '0;
                    done_d  = 1'b1;
                    if (!we_q)
                        rdata_d = extract(size_q, adr_q[1:0], DAT_I);
`ifdef WB_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = RELEASE;
                    stb_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = '0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            RELEASE: begin
                // a still-high ACK belongs to the finished transfer; wait it out
                if (!ACK_I) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            size_q  <= 2'b00;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            rdata_q <= '0;
`ifdef WB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            size_q  <= size_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
`ifdef WB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign ready_o = ready_q;
    assign done_o  = done_q;
    assign rdata_o = rdata_q;
    assign ADR_O   = adr_q;
    assign DAT_O   = dat_q;
    assign WE_O    = we_q;
    assign SEL_O   = sel_q;
    assign STB_O   = stb_q;
    assign CYC_O   = stb_q;
`ifdef WB_TIMEOUT_EN
    assign err_o   = err_q;
`else
    assign err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_master.sv
// Bench for wb_master: directed and randomized transfers against a byte-lane reference model.
module tb_wb_master;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [1:0]  size_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ready_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic [31:0] ADR_O;
    logic [31:0] DAT_O;
    logic [31:0] DAT_I;
    logic        WE_O;
    logic [3:0]  SEL_O;
    logic        STB_O;
    logic        CYC_O;
    logic        ACK_I;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_rdata;

    wb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .size_i(size_i),
        .addr_i(addr_i), .wdata_i(wdata_i), .ready_o(ready_o), .done_o(done_o),
        .rdata_o(rdata_o), .err_o(err_o), .ADR_O(ADR_O), .DAT_O(DAT_O), .DAT_I(DAT_I),
        .WE_O(WE_O), .SEL_O(SEL_O), .STB_O(STB_O), .CYC_O(CYC_O), .ACK_I(ACK_I)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: an access covers n = 1/2/4 bytes at the naturally aligned base
    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    function automatic int base_of(input logic [1:0] size, input logic [31:0] addr);
        return int'(addr % 4) / nbytes(size) * nbytes(size);
    endfunction

    function automatic logic [3:0] model_sel(input logic [1:0] size, input logic [31:0] addr);
        return 4'(((1 << nbytes(size)) - 1) << base_of(size, addr));
    endfunction

    function automatic logic [31:0] model_dat(input logic [1:0] size, input logic [31:0] w);
        logic [31:0] r = 0;
        for (int k = 0; k < 4; k++)
            r = r | (((w >> (8 * (k % nbytes(size)))) & 32'hFF) << (8 * k));
        return r;
    endfunction

    function automatic logic [31:0] model_rd(input logic [1:0] size, input logic [31:0] addr,
                                             input logic [31:0] d);
        longint unsigned mask = (64'd1 << (8 * nbytes(size))) - 1;
        return 32'((longint'(d) >> (8 * base_of(size, addr))) & mask);
    endfunction

    task automatic txn(input logic we, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] dati,
                       input int ack_delay, input int hold_extra, input bit hold_req);
        int n;
        req_i = 1'b1; we_i = we; size_i = size; addr_i = addr; wdata_i = wdata;
        n = 0;
        while (n < 10) begin
            @(negedge clk);
            n++;
            if (STB_O) break;
        end
        check("accept_latency", n, 1);
        if (!hold_req) req_i = 1'b0;
        check("ready_low", ready_o, 0);
        check("cyc_high", CYC_O, 1);
        check("adr", ADR_O, addr);
        check("sel", SEL_O, model_sel(size, addr));
        check("we", WE_O, we);
        check("dat_o", DAT_O, we ? model_dat(size, wdata) : 32'd0);
        for (int i = 0; i < ack_delay; i++) begin
            @(negedge clk);
            check("stb_hold", STB_O, 1);
            check("no_early_done", done_o, 0);
        end
        ACK_I = 1'b1; DAT_I = dati;
        @(negedge clk);
        if (!we) exp_rdata = model_rd(size, addr, dati);
        check("done_pulse", done_o, 1);
        check("stb_drop", STB_O, 0);
        check("cyc_drop", CYC_O, 0);
        check("sel_clear", SEL_O, 0);
        check("err_clear", err_o, 0);
        check("rdata", rdata_o, exp_rdata);
        DAT_I = $urandom;
        for (int i = 0; i < hold_extra; i++) begin
            @(negedge clk);
            check("single_done", done_o, 0);
            check("no_restb", STB_O, 0);
            check("not_ready", ready_o, 0);
        end
        ACK_I = 1'b0;
        @(negedge clk);
        check("release_done", done_o, 0);
        check("ready_back", ready_o, 1);
        check("rdata_hold", rdata_o, exp_rdata);
    endtask

    initial begin
        int n;
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; size_i = 2'b00; addr_i = 0;
        wdata_i = 0; DAT_I = 0; ACK_I = 1'b0; exp_rdata = 0;
        repeat (3) @(negedge clk);
        check("rst_ready", ready_o, 1);
        check("rst_stb", STB_O, 0);
        check("rst_cyc", CYC_O, 0);
        check("rst_done", done_o, 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_sel", SEL_O, 0);
        rst_i = 1'b0;
        @(negedge clk);

        txn(1'b1, 2'b10, 32'h10, 32'hDEADBEEF, 32'h0, 2, 1, 1'b0);
        txn(1'b0, 2'b00, 32'h13, 32'h0, 32'hA1B2C3D4, 1, 1, 1'b0);
        check("byte_read_a1", rdata_o, 32'h000000A1);
        txn(1'b1, 2'b01, 32'h22, 32'h00001234, 32'h0, 0, 1, 1'b0);
        txn(1'b0, 2'b01, 32'h22, 32'h0, 32'hCAFEF00D, 0, 1, 1'b0);
        check("half_read_hi", rdata_o, 32'h0000CAFE);

        // core holds req_i across back-to-back transfers with a held ACK
        txn(1'b0, 2'b10, 32'h40, 32'h0, 32'h11223344, 1, 1, 1'b1);
        txn(1'b1, 2'b00, 32'h41, 32'h000000AB, 32'h0, 0, 2, 1'b1);
        txn(1'b0, 2'b00, 32'h42, 32'h0, 32'h55667788, 0, 1, 1'b0);

        for (int t = 0; t < 40; t++)
            txn(1'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'($urandom));
        req_i = 1'b0;
        @(negedge clk);

        // reset while waiting for ACK abandons the transfer
        req_i = 1'b1; we_i = 1'b0; size_i = 2'b10; addr_i = 32'h80;
        @(negedge clk);
        req_i = 1'b0;
        check("pre_rst_stb", STB_O, 1);
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        exp_rdata = 0;
        check("midrst_stb", STB_O, 0);
        check("midrst_cyc", CYC_O, 0);
        check("midrst_ready", ready_o, 1);
        check("midrst_done", done_o, 0);
        @(negedge clk);
        check("postrst_done", done_o, 0);

`ifdef WB_TIMEOUT_EN
        txn(1'b0, 2'b10, 32'h90, 32'h0, 32'h12345678, 0, 0, 1'b0);
        req_i = 1'b1; we_i = 1'b0; size_i = 2'b10; addr_i = 32'hA0;
        @(negedge clk);
        req_i = 1'b0;
        check("to_stb", STB_O, 1);
        n = 1;
        while (n < 50) begin
            @(negedge clk);
            if (!STB_O) break;
            check("to_no_done", done_o, 0);
            n++;
        end
        check("to_stb_cycles", n, 8);
        check("to_done", done_o, 1);
        check("to_err", err_o, 1);
        check("to_rdata", rdata_o, 0);
        @(negedge clk);
        check("to_ready", ready_o, 1);
        check("to_done_low", done_o, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
